// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with a two-entry skid buffer, freeze and flush.
// in_ready depends only on Freeze and the registered state, so downstream stalls never reach upstream combinationally.
module exe_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Freeze,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic              WB_EN_in,
    input  logic [DEST_W-1:0] Dest_in,
    input  logic [DATA_W-1:0] ALU_Res_in,
    input  logic [DATA_W-1:0] Val_Rm_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              MEM_R_EN_out,
    output logic              MEM_W_EN_out,
    output logic              WB_EN_out,
    output logic [DEST_W-1:0] Dest_out,
    output logic [DATA_W-1:0] ALU_Res_out,
    output logic [DATA_W-1:0] Val_Rm_out,
    output logic [1:0]        occupancy
);

    // state | meaning
    // EMPTY | no entries held
    // ONE   | main (head) entry valid
    // FULL  | main and skid valid; skid is the younger entry
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic              mem_r_en;
        logic              mem_w_en;
        logic              wb_en;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] val_rm;
    } entry_t;

    state_t state;
    state_t state_nxt;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   accept;
    logic   emit;
    logic   load_main_in;
    logic   load_main_skid;
    logic   load_skid_in;

    assign in_entry = '{mem_r_en: MEM_R_EN_in, mem_w_en: MEM_W_EN_in, wb_en: WB_EN_in,
                        dest: Dest_in, alu_res: ALU_Res_in, val_rm: Val_Rm_in};

    assign in_ready  = ~Freeze & (state != FULL);
    assign out_valid = ~Freeze & (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Freeze needs no explicit term: it forces accept and emit low, so everything holds.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (Flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_nxt    = FULL;
                        load_skid_in = 1'b1;
                    end else if (emit) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid_in) begin
                skid_q <= in_entry;
            end
        end
    end

    // Control bits are gated so a flushed or frozen head can never trigger a memory access.
    assign MEM_R_EN_out = out_valid & main_q.mem_r_en;
    assign MEM_W_EN_out = out_valid & main_q.mem_w_en;
    assign WB_EN_out    = out_valid & main_q.wb_en;
    assign Dest_out     = main_q.dest;
    assign ALU_Res_out  = main_q.alu_res;
    assign Val_Rm_out   = main_q.val_rm;
    assign occupancy    = state;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Bench for exe_mem_pipe_reg: per-cycle vector table for handshake/occupancy plus a
// queue scoreboard for payload ordering; extra sequences for async reset and wide parameters.
module tb_exe_mem_pipe_reg;

    logic        clk;
    logic        rst;
    logic        Freeze;
    logic        Flush;
    logic        in_valid;
    logic        in_ready;
    logic        MEM_R_EN_in;
    logic        MEM_W_EN_in;
    logic        WB_EN_in;
    logic [3:0]  Dest_in;
    logic [31:0] ALU_Res_in;
    logic [31:0] Val_Rm_in;
    logic        out_valid;
    logic        out_ready;
    logic        MEM_R_EN_out;
    logic        MEM_W_EN_out;
    logic        WB_EN_out;
    logic [3:0]  Dest_out;
    logic [31:0] ALU_Res_out;
    logic [31:0] Val_Rm_out;
    logic [1:0]  occupancy;

    logic        p_in_valid;
    logic        p_in_ready;
    logic        p_out_valid;
    logic        p_mem_r_out;
    logic        p_mem_w_out;
    logic        p_wb_out;
    logic [4:0]  p_dest_in;
    logic [4:0]  p_dest_out;
    logic [63:0] p_alu_in;
    logic [63:0] p_alu_out;
    logic [63:0] p_val_in;
    logic [63:0] p_val_out;
    logic [1:0]  p_occupancy;

    exe_mem_pipe_reg dut (
        .clk(clk), .rst(rst), .Freeze(Freeze), .Flush(Flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
        .Dest_in(Dest_in), .ALU_Res_in(ALU_Res_in), .Val_Rm_in(Val_Rm_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out), .WB_EN_out(WB_EN_out),
        .Dest_out(Dest_out), .ALU_Res_out(ALU_Res_out), .Val_Rm_out(Val_Rm_out),
        .occupancy(occupancy)
    );

    exe_mem_pipe_reg #(.DATA_W(64), .DEST_W(5)) dut_w (
        .clk(clk), .rst(rst), .Freeze(1'b0), .Flush(1'b0),
        .in_valid(p_in_valid), .in_ready(p_in_ready),
        .MEM_R_EN_in(1'b1), .MEM_W_EN_in(1'b0), .WB_EN_in(1'b1),
        .Dest_in(p_dest_in), .ALU_Res_in(p_alu_in), .Val_Rm_in(p_val_in),
        .out_valid(p_out_valid), .out_ready(1'b1),
        .MEM_R_EN_out(p_mem_r_out), .MEM_W_EN_out(p_mem_w_out), .WB_EN_out(p_wb_out),
        .Dest_out(p_dest_out), .ALU_Res_out(p_alu_out), .Val_Rm_out(p_val_out),
        .occupancy(p_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        freeze;
        logic        flush;
        logic        iv;
        logic        ordy;
        logic [31:0] alu;
        logic [1:0]  exp_occ;
        logic        exp_ir;
        logic        exp_ov;
    } vec_t;

    typedef struct {
        logic        r;
        logic        w;
        logic        wb;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic [31:0] val;
    } ent_t;

    vec_t vecs[24];
    ent_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic fz, input logic fl, input logic iv, input logic ordy,
                                input logic [31:0] alu, input logic [1:0] occ,
                                input logic ir, input logic ov);
        vec_t v;
        v.freeze = fz; v.flush = fl; v.iv = iv; v.ordy = ordy; v.alu = alu;
        v.exp_occ = occ; v.exp_ir = ir; v.exp_ov = ov;
        return v;
    endfunction

    // Payload is derived from the ALU value so each entry is uniquely identifiable.
    function automatic ent_t ent_of(input logic [31:0] alu);
        ent_t e;
        e.r = alu[0]; e.w = alu[1]; e.wb = alu[2];
        e.dest = alu[3:0]; e.alu = alu; e.val = ~alu;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fz, input logic fl, input logic iv, input logic ordy,
                         input logic [31:0] alu);
        ent_t e;
        e = ent_of(alu);
        Freeze = fz; Flush = fl; in_valid = iv; out_ready = ordy;
        MEM_R_EN_in = e.r; MEM_W_EN_in = e.w; WB_EN_in = e.wb;
        Dest_in = e.dest; ALU_Res_in = e.alu; Val_Rm_in = e.val;
    endtask

    task automatic step(input vec_t v, input int idx);
        ent_t h;
        @(negedge clk);
        drive(v.freeze, v.flush, v.iv, v.ordy, v.alu);
        #1;
        chk($sformatf("occupancy[%0d]", idx), 64'(occupancy), 64'(v.exp_occ));
        chk($sformatf("in_ready[%0d]", idx), 64'(in_ready), 64'(v.exp_ir));
        chk($sformatf("out_valid[%0d]", idx), 64'(out_valid), 64'(v.exp_ov));
        if (v.exp_ov) begin
            if (sb.size() == 0) begin
                chk($sformatf("sb_nonempty[%0d]", idx), 64'(out_valid), 64'(0));
            end else begin
                h = sb[0];
                chk($sformatf("alu_out[%0d]", idx), 64'(ALU_Res_out), 64'(h.alu));
                chk($sformatf("dest_out[%0d]", idx), 64'(Dest_out), 64'(h.dest));
                chk($sformatf("val_out[%0d]", idx), 64'(Val_Rm_out), 64'(h.val));
                chk($sformatf("ctrl_out[%0d]", idx),
                    64'({MEM_R_EN_out, MEM_W_EN_out, WB_EN_out}), 64'({h.r, h.w, h.wb}));
            end
        end else begin
            chk($sformatf("ctrl_gated[%0d]", idx),
                64'({MEM_R_EN_out, MEM_W_EN_out, WB_EN_out}), 64'(0));
        end
        // Scoreboard update for the coming edge: flush wins, else pop before push keeps FIFO order.
        if (v.flush) begin
            sb.delete();
        end else begin
            if (v.exp_ov && v.ordy && sb.size() > 0) void'(sb.pop_front());
            if (v.iv && v.exp_ir) sb.push_back(ent_of(v.alu));
        end
    endtask

    initial begin
        // Streaming
        vecs[0]  = mk(0, 0, 1, 1, 32'h01, 2'd0, 1, 0);
        vecs[1]  = mk(0, 0, 1, 1, 32'h02, 2'd1, 1, 1);
        vecs[2]  = mk(0, 0, 1, 1, 32'h03, 2'd1, 1, 1);
        vecs[3]  = mk(0, 0, 0, 1, 32'h00, 2'd1, 1, 1);
        // Skid: A, B under 2 cycles of back-pressure, then drain
        vecs[4]  = mk(0, 0, 1, 0, 32'h10, 2'd0, 1, 0);
        vecs[5]  = mk(0, 0, 1, 0, 32'h20, 2'd1, 1, 1);
        vecs[6]  = mk(0, 0, 0, 0, 32'h00, 2'd2, 0, 1);
        vecs[7]  = mk(0, 0, 0, 1, 32'h00, 2'd2, 0, 1);
        vecs[8]  = mk(0, 0, 0, 1, 32'h00, 2'd1, 1, 1);
        vecs[9]  = mk(0, 0, 0, 1, 32'h00, 2'd0, 1, 0);
        // Freeze with FULL for 3 cycles, held input 0x50 accepted only after A, B
        vecs[10] = mk(0, 0, 1, 0, 32'h30, 2'd0, 1, 0);
        vecs[11] = mk(0, 0, 1, 0, 32'h40, 2'd1, 1, 1);
        vecs[12] = mk(1, 0, 1, 1, 32'h50, 2'd2, 0, 0);
        vecs[13] = mk(1, 0, 1, 1, 32'h50, 2'd2, 0, 0);
        vecs[14] = mk(1, 0, 1, 1, 32'h50, 2'd2, 0, 0);
        vecs[15] = mk(0, 0, 1, 1, 32'h50, 2'd2, 0, 1);
        vecs[16] = mk(0, 0, 1, 1, 32'h50, 2'd1, 1, 1);
        vecs[17] = mk(0, 0, 0, 1, 32'h00, 2'd1, 1, 1);
        // Flush + Freeze + in_valid with a store at the head
        vecs[18] = mk(0, 0, 1, 0, 32'h62, 2'd0, 1, 0);
        vecs[19] = mk(0, 0, 1, 0, 32'h70, 2'd1, 1, 1);
        vecs[20] = mk(1, 1, 1, 0, 32'h80, 2'd2, 0, 0);
        vecs[21] = mk(0, 0, 0, 1, 32'h00, 2'd0, 1, 0);
        vecs[22] = mk(0, 0, 1, 1, 32'h93, 2'd0, 1, 0);
        vecs[23] = mk(0, 0, 0, 1, 32'h00, 2'd1, 1, 1);

        rst = 1'b1;
        drive(0, 0, 0, 0, 32'h0);
        p_in_valid = 1'b0; p_dest_in = '0; p_alu_in = '0; p_val_in = '0;
        #2;
        chk("rst_occupancy", 64'(occupancy), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_alu_out", 64'(ALU_Res_out), 64'(0));
        chk("rst_dest_out", 64'(Dest_out), 64'(0));
        chk("rst_val_out", 64'(Val_Rm_out), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) step(vecs[i], i);

        // Async reset while FULL, checked before the next rising edge
        step(mk(0, 0, 1, 0, 32'hA1, 2'd0, 1, 0), 100);
        step(mk(0, 0, 1, 0, 32'hB2, 2'd1, 1, 1), 101);
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0);
        #1;
        chk("pre_rst_occupancy", 64'(occupancy), 64'(2));
        rst = 1'b1;
        #1;
        chk("async_rst_occupancy", 64'(occupancy), 64'(0));
        chk("async_rst_out_valid", 64'(out_valid), 64'(0));
        chk("async_rst_in_ready", 64'(in_ready), 64'(1));
        chk("async_rst_alu_out", 64'(ALU_Res_out), 64'(0));
        chk("async_rst_ctrl", 64'({MEM_R_EN_out, MEM_W_EN_out, WB_EN_out}), 64'(0));
        #1;
        rst = 1'b0;
        sb.delete();
        step(mk(0, 0, 1, 1, 32'hA5, 2'd0, 1, 0), 102);
        step(mk(0, 0, 0, 1, 32'h00, 2'd1, 1, 1), 103);
        step(mk(0, 0, 0, 1, 32'h00, 2'd0, 1, 0), 104);

        // Wide-parameter instance
        @(negedge clk);
        p_in_valid = 1'b1;
        p_dest_in  = 5'd31;
        p_alu_in   = 64'hFFFF_FFFF_0000_0001;
        p_val_in   = 64'h8000_0000_0000_00FE;
        #1;
        chk("w_in_ready", 64'(p_in_ready), 64'(1));
        @(negedge clk);
        p_in_valid = 1'b0;
        #1;
        chk("w_out_valid", 64'(p_out_valid), 64'(1));
        chk("w_dest_out", 64'(p_dest_out), 64'(31));
        chk("w_alu_out", p_alu_out, 64'hFFFF_FFFF_0000_0001);
        chk("w_val_out", p_val_out, 64'h8000_0000_0000_00FE);
        chk("w_ctrl_out", 64'({p_mem_r_out, p_mem_w_out, p_wb_out}), 64'(3'b101));
        chk("w_occupancy", 64'(p_occupancy), 64'(1));
        @(negedge clk);
        #1;
        chk("w_drained", 64'(p_occupancy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
